alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the miniGPU per-thread datapath: the next generation of the single-cycle ALU. It generalises the data width, adds an iterative restoring divider, a compare mode producing NZP flags, and a start/busy/done handshake so the core scheduler can stall on long operations. There is one instance per thread lane, and it is driven by the decoder and the core state machine during the EXECUTE state.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_divider.sv | 59 +++++
 rtl/alu_mc.sv | 172 +++++++++++++++++
 tb/tb_alu_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the miniGPU multi-cycle ALU: op codes, output mux,
// FSM states and the default EXECUTE core-state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    localparam logic OUT_ARITH = 1'b0;
    localparam logic OUT_CMP   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_DIV_RUN = 2'b01,
        S_DONE    = 2'b10
    } alu_state_e;

    localparam logic [2:0] DEFAULT_EXECUTE_STATE = 3'b101;

    function automatic logic [2:0] nzp_flags(input logic lt, input logic eq);
        return {lt, eq, (!lt) && (!eq)};
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring shift-subtract divider: one quotient bit per enabled cycle,
// DATA_WIDTH iterations after the load cycle.
module alu_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic                  o_done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_div;
    logic [CW-1:0]         r_cnt;
    logic                  r_run;

    logic [DATA_WIDTH:0]   w_trial;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_fits;

    // The dividend shifts out of r_quo's top while quotient bits shift in at the bottom.
    assign w_trial = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_div};
    assign w_fits  = ~w_diff[DATA_WIDTH];

    // Operand load on start, one iteration per enabled cycle while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (i_enable && r_run) begin
            r_rem <= w_fits ? w_diff[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + CW'(1);
            r_run <= (r_cnt != LAST_ITER);
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_run && (r_cnt == LAST_ITER);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle per-lane ALU with start/busy/done handshake and NZP compare.
// Define ALU_MC_DIV_EN to build the iterative divider; otherwise DIV reports divide-by-zero.
module alu_mc
    import alu_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [2:0] EXECUTE_STATE = DEFAULT_EXECUTE_STATE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            core_state,
    input  logic                  start,
    input  logic [1:0]            decoded_alu_arithmetic_mux,
    input  logic                  decoded_alu_output_mux,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [2:0]            alu_nzp,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    alu_state_e            r_state;
    alu_state_e            w_next;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    alu_op_e               r_op;
    logic                  r_cmp;
    logic                  r_dbz_pend;
    logic [DATA_WIDTH-1:0] r_alu_out;
    logic [2:0]            r_nzp;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_div_by_zero;

    logic                  w_issue;
    logic                  w_is_div;
    logic                  w_div_zero;
    logic                  w_div_long;
    logic                  w_div_last;
    logic [2:0]            w_nzp;
    logic [DATA_WIDTH-1:0] w_mul;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_issue  = enable && (core_state == EXECUTE_STATE) && start
                      && !r_busy && (r_state == S_IDLE);
    assign w_is_div = (decoded_alu_output_mux == OUT_ARITH)
                      && (decoded_alu_arithmetic_mux == OP_DIV);

`ifdef ALU_MC_DIV_EN
    logic [DATA_WIDTH-1:0] w_div_quo;

    assign w_div_zero = w_is_div && (rt == {DATA_WIDTH{1'b0}});
    assign w_div_long = w_is_div && (rt != {DATA_WIDTH{1'b0}});

    alu_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divider (
        .clk        (clk),
        .reset      (reset),
        .i_enable   (enable),
        .i_start    (w_issue && w_div_long),
        .i_dividend (rs),
        .i_divisor  (rt),
        .o_quotient (w_div_quo),
        .o_done     (w_div_last)
    );
`else
    assign w_div_zero = w_is_div;
    assign w_div_long = 1'b0;
    assign w_div_last = 1'b0;
`endif

    // FSM state register; a disabled lane holds its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next = w_div_long ? S_DIV_RUN : S_DONE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DIV_RUN: begin
                if (w_div_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DIV_RUN;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_mul = r_a * r_b;

    // Result selection from the operands captured at issue.
    always_comb begin
        w_nzp    = nzp_flags(r_a < r_b, r_a == r_b);
        w_result = {DATA_WIDTH{1'b0}};
        if (r_cmp) begin
            w_result = {{(DATA_WIDTH-3){1'b0}}, w_nzp};
        end else begin
            case (r_op)
                OP_ADD: w_result = r_a + r_b;
                OP_SUB: w_result = r_a - r_b;
                OP_MUL: w_result = w_mul;
                OP_DIV: begin
`ifdef ALU_MC_DIV_EN
                    w_result = r_dbz_pend ? {DATA_WIDTH{1'b1}} : w_div_quo;
`else
                    w_result = {DATA_WIDTH{1'b0}};
`endif
                end
                default: w_result = {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // Operand capture at issue and registered outputs written in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= OP_ADD;
            r_cmp         <= 1'b0;
            r_dbz_pend    <= 1'b0;
            r_alu_out     <= '0;
            r_nzp         <= 3'b000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else if (enable) begin
            r_done <= (r_state == S_DONE);
            r_busy <= (r_state == S_DIV_RUN);
            if (w_issue) begin
                r_a           <= rs;
                r_b           <= rt;
                r_op          <= alu_op_e'(decoded_alu_arithmetic_mux);
                r_cmp         <= decoded_alu_output_mux;
                r_dbz_pend    <= w_div_zero;
                r_div_by_zero <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_alu_out     <= w_result;
                r_div_by_zero <= r_dbz_pend;
                if (r_cmp) begin
                    r_nzp <= w_nzp;
                end
            end
        end
    end

    assign alu_out     = r_alu_out;
    assign alu_nzp     = r_nzp;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: issue pushes the expected result and completion
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_alu_mc;

    localparam int W = 8;
    localparam logic [2:0] EXEC = 3'b101;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b1;
    logic [2:0]   core_state = EXEC;
    logic         start = 1'b0;
    logic [1:0]   amux = 2'b00;
    logic         omux = 1'b0;
    logic [W-1:0] rs = 8'd0;
    logic [W-1:0] rt = 8'd0;
    logic [W-1:0] alu_out;
    logic [2:0]   alu_nzp;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        logic [7:0] out;
        logic [2:0] nzp;
        logic       dbz;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_mc #(.DATA_WIDTH(W), .EXECUTE_STATE(EXEC)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .enable                     (enable),
        .core_state                 (core_state),
        .start                      (start),
        .decoded_alu_arithmetic_mux (amux),
        .decoded_alu_output_mux     (omux),
        .rs                         (rs),
        .rt                         (rt),
        .alu_out                    (alu_out),
        .alu_nzp                    (alu_nzp),
        .busy                       (busy),
        .done                       (done),
        .div_by_zero                (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (busy) busy_cnt = busy_cnt + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks = n_checks + 1;
        if (got != want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_out"}, int'(alu_out), int'(e.out));
                check({e.name, "_nzp"}, int'(alu_nzp), int'(e.nzp));
                check({e.name, "_dbz"}, int'(div_by_zero), int'(e.dbz));
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Caller is at a negedge; the op is sampled at the next posedge.
    task automatic issue(input logic [1:0] op, input logic cmp, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] e_out, input logic [2:0] e_nzp,
                         input logic e_dbz, input int lat, input string name);
        exp_t e;
        rs = a; rt = b; amux = op; omux = cmp; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = 0;
        e.out = e_out; e.nzp = e_nzp; e.dbz = e_dbz; e.cyc = cyc + lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int want_busy);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_busy_cycles"}, busy_cnt, want_busy);
        end
    endtask

    initial begin
        #22;
        check("rst_alu_out", int'(alu_out), 0);
        check("rst_nzp", int'(alu_nzp), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(2'b00, 1'b0, 8'd10, 8'd5, 8'd15, 3'b000, 1'b0, 1, "add_10_5");
        wait_done("add_10_5", 0);
        issue(2'b01, 1'b0, 8'd10, 8'd5, 8'd5, 3'b000, 1'b0, 1, "sub_10_5");
        wait_done("sub_10_5", 0);
        issue(2'b10, 1'b0, 8'd20, 8'd13, 8'd4, 3'b000, 1'b0, 1, "mul_20_13");
        wait_done("mul_20_13", 0);
        issue(2'b00, 1'b1, 8'd3, 8'd7, 8'h04, 3'b100, 1'b0, 1, "cmp_3_7");
        wait_done("cmp_3_7", 0);
        issue(2'b01, 1'b1, 8'd9, 8'd9, 8'h02, 3'b010, 1'b0, 1, "cmp_9_9");
        wait_done("cmp_9_9", 0);
        issue(2'b11, 1'b1, 8'd200, 8'd1, 8'h01, 3'b001, 1'b0, 1, "cmp_200_1");
        wait_done("cmp_200_1", 0);
        issue(2'b01, 1'b0, 8'd5, 8'd10, 8'd251, 3'b001, 1'b0, 1, "sub_wrap");
        wait_done("sub_wrap", 0);

        // Requests outside EXECUTE or with the lane disabled must not issue.
        core_state = 3'b000; start = 1'b1;
        repeat (2) @(negedge clk);
        core_state = EXEC; enable = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);

`ifdef ALU_MC_DIV_EN
        issue(2'b11, 1'b0, 8'd100, 8'd7, 8'd14, 3'b001, 1'b0, W + 1, "div_100_7");
        repeat (3) @(negedge clk);
        rs = 8'd1; rt = 8'd1; amux = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("div_100_7", W);
        issue(2'b11, 1'b0, 8'd42, 8'd0, 8'hFF, 3'b001, 1'b1, 1, "div_by_0");
        wait_done("div_by_0", 0);
        issue(2'b00, 1'b0, 8'd250, 8'd10, 8'd4, 3'b001, 1'b0, 1, "add_clear_dbz");
        wait_done("add_clear_dbz", 0);

        issue(2'b11, 1'b0, 8'd255, 8'd16, 8'd15, 3'b001, 1'b0, W + 1 + 3, "div_stall");
        repeat (2) @(negedge clk);
        core_state = 3'b000;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_done("div_stall", W + 3);
        core_state = EXEC;
        @(negedge clk);

        issue(2'b11, 1'b0, 8'd100, 8'd7, 8'd14, 3'b001, 1'b0, W + 1, "div_aborted");
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        check("midrst_alu_out", int'(alu_out), 0);
        check("midrst_nzp", int'(alu_nzp), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        issue(2'b00, 1'b0, 8'd1, 8'd2, 8'd3, 3'b000, 1'b0, 1, "add_after_rst");
        wait_done("add_after_rst", 0);
`else
        issue(2'b11, 1'b0, 8'd100, 8'd7, 8'd0, 3'b001, 1'b1, 1, "div_nodiv");
        wait_done("div_nodiv", 0);
        issue(2'b00, 1'b0, 8'd250, 8'd10, 8'd4, 3'b001, 1'b0, 1, "add_clear_dbz");
        wait_done("add_clear_dbz", 0);
        issue(2'b11, 1'b0, 8'd9, 8'd0, 8'd0, 3'b001, 1'b1, 1, "div0_nodiv");
        wait_done("div0_nodiv", 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
